seg7_scan_driver: RTL and testbench

- Parametrised, time-multiplexed driver for an N-digit common-anode/cathode seven-segment display.
- Holds a latched hex word, scans one digit per refresh slot, and applies dead-time blanking, per-digit blank/decimal point and optional leading-zero suppression.
- Tear-free update: new values take effect only at frame boundaries.
- Sits between datapath/status logic and the board display pins. It is the clocked successor of the combinational hex-to-segment decoder.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_font.sv | 15 +
 rtl/seg7_scan_driver.sv | 204 ++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared font table, dark-segment constant and polarity helper for the
// seven-segment scan driver.
package seg7_pkg;

    // Active-high {a,b,c,d,e,f,g} patterns for hex digits 0..F.
    localparam logic [6:0] SEG_FONT [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    localparam logic [6:0] SEG_DARK = 7'b0000000;

    function automatic logic [6:0] seg_polarity(input logic [6:0] seg, input logic active_low);
        return active_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/seg7_font.sv
// Combinational hex nibble to seven-segment lookup with pin polarity applied.
module seg7_font
    import seg7_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg_polarity(SEG_FONT[nibble], SEG_ACTIVE_LOW);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with dead-time blanking,
// leading-zero suppression and frame-synchronous (tear-free) updates.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter int unsigned BLANK_CYCLES   = 2,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    input  logic                    enable,
    input  logic                    lz_suppress,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [IDX_W-1:0]        scan_idx,
    output logic                    frame_done
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF   = seg_polarity(SEG_DARK, SEG_ACTIVE_LOW);
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_ACTIVE_LOW}};

    // Scan position
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             slot_end;
    logic             frame_end;

    // Pending (written by load) and display (used by the scan) banks
    logic [NUM_DIGITS-1:0][3:0] digits_arr;
    logic [NUM_DIGITS-1:0][3:0] pend_digits_q, pend_digits_d;
    logic [NUM_DIGITS-1:0]      pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]      pend_blank_q, pend_blank_d;
    logic                       pend_valid_q, pend_valid_d;
    logic [NUM_DIGITS-1:0][3:0] disp_digits_q, disp_digits_d;
    logic [NUM_DIGITS-1:0]      disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0]      disp_blank_q, disp_blank_d;

    // Output path
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  higher_clear;
    logic [3:0]            cur_nibble;
    logic [6:0]            font_seg;
    logic                  digit_dark;
    logic [NUM_DIGITS-1:0] an_onehot;
    logic [6:0]            seg_d;
    logic                  dp_d;
    logic [NUM_DIGITS-1:0] an_d;
    logic [IDX_W-1:0]      scan_idx_d;
    logic                  frame_done_d;

    assign digits_arr = digits_in;

    always_comb begin
        slot_end  = enable && (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);
    end

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!enable) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // A load coinciding with the frame boundary bypasses the pending bank so
    // it shows in the very next frame instead of one frame later.
    always_comb begin
        pend_digits_d = pend_digits_q;
        pend_dp_d     = pend_dp_q;
        pend_blank_d  = pend_blank_q;
        pend_valid_d  = pend_valid_q;
        disp_digits_d = disp_digits_q;
        disp_dp_d     = disp_dp_q;
        disp_blank_d  = disp_blank_q;

        if (load) begin
            pend_digits_d = digits_arr;
            pend_dp_d     = dp_in;
            pend_blank_d  = blank_in;
            pend_valid_d  = 1'b1;
        end

        if (frame_end) begin
            if (load) begin
                disp_digits_d = digits_arr;
                disp_dp_d     = dp_in;
                disp_blank_d  = blank_in;
                pend_valid_d  = 1'b0;
            end else if (pend_valid_q) begin
                disp_digits_d = pend_digits_q;
                disp_dp_d     = pend_dp_q;
                disp_blank_d  = pend_blank_q;
                pend_valid_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            pend_digits_q <= '0;
            pend_dp_q     <= '0;
            pend_blank_q  <= '0;
            pend_valid_q  <= 1'b0;
            disp_digits_q <= '0;
            disp_dp_q     <= '0;
            disp_blank_q  <= '0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            pend_digits_q <= pend_digits_d;
            pend_dp_q     <= pend_dp_d;
            pend_blank_q  <= pend_blank_d;
            pend_valid_q  <= pend_valid_d;
            disp_digits_q <= disp_digits_d;
            disp_dp_q     <= disp_dp_d;
            disp_blank_q  <= disp_blank_d;
        end
    end

    // Walk from the most significant digit down; a zero stays "leading" while
    // every digit above it is zero or blanked. Digit 0 is always shown.
    always_comb begin
        lead_zero    = '0;
        higher_clear = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            lead_zero[k] = (k != 0) && higher_clear && (disp_digits_q[k] == 4'h0);
            higher_clear = higher_clear && ((disp_digits_q[k] == 4'h0) || disp_blank_q[k]);
        end
    end

    assign cur_nibble = disp_digits_q[idx_q];

    seg7_font #(
        .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_font (
        .nibble(cur_nibble),
        .seg   (font_seg)
    );

    always_comb begin
        digit_dark = disp_blank_q[idx_q] || (lz_suppress && lead_zero[idx_q]);
        an_onehot  = '0;
        an_onehot[idx_q] = 1'b1;
    end

    always_comb begin
        seg_d        = SEG_OFF;
        dp_d         = SEG_ACTIVE_LOW;
        an_d         = AN_OFF;
        scan_idx_d   = '0;
        frame_done_d = 1'b0;
        if (enable) begin
            scan_idx_d   = idx_q;
            frame_done_d = frame_end;
            if (cnt_q >= BLANK_END) begin
                an_d = AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
                if (!digit_dark) begin
                    seg_d = font_seg;
                    dp_d  = disp_dp_q[idx_q] ^ SEG_ACTIVE_LOW;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out    <= SEG_OFF;
            dp_out     <= SEG_ACTIVE_LOW;
            an_out     <= AN_OFF;
            scan_idx   <= '0;
            frame_done <= 1'b0;
        end else begin
            seg_out    <= seg_d;
            dp_out     <= dp_d;
            an_out     <= an_d;
            scan_idx   <= scan_idx_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: active-low and active-high instances
// share stimulus and are checked against a frame-level display model.
module tb_seg7_scan_driver;

    localparam int N = 4;
    localparam int R = 4;
    localparam int B = 1;
    localparam int FRAME = N * R;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] idx;
        logic       fd;
    } pins_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic        load = 1'b0;
    logic        enable = 1'b0;
    logic        lz = 1'b0;

    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [3:0] an_a, an_b;
    logic [1:0] idx_a, idx_b;
    logic       fd_a, fd_b;
    logic [29:0] got;

    int n_tests = 0;
    int n_fail  = 0;

    logic [29:0] sb[$];
    logic [29:0] exp_v;

    // Reference display state
    int          m_pos;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_disp_dp, m_pend_dp, m_disp_bl, m_pend_bl;
    bit          m_pv;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut_lo (
        .clk(clk), .rst_n(rst_n), .digits_in(digits), .dp_in(dp_in), .blank_in(blank_in),
        .load(load), .enable(enable), .lz_suppress(lz),
        .seg_out(seg_a), .dp_out(dp_a), .an_out(an_a), .scan_idx(idx_a), .frame_done(fd_a)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B),
        .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
    ) dut_hi (
        .clk(clk), .rst_n(rst_n), .digits_in(digits), .dp_in(dp_in), .blank_in(blank_in),
        .load(load), .enable(enable), .lz_suppress(lz),
        .seg_out(seg_b), .dp_out(dp_b), .an_out(an_b), .scan_idx(idx_b), .frame_done(fd_b)
    );

    assign got = {an_a, seg_a, dp_a, idx_a, fd_a, an_b, seg_b, dp_b, idx_b, fd_b};

    function automatic logic [6:0] font(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;  4'h9: return 7'b1110011;
            4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;  default: return 7'b1000111;
        endcase
    endfunction

    // Expected active-high pins for the state about to be clocked out.
    function automatic pins_t model_hi();
        pins_t r;
        int    k, c;
        logic  dark, z;
        r = '0;
        if (!enable) return r;
        k = m_pos / R;
        c = m_pos % R;
        r.idx = 2'(k);
        r.fd  = (m_pos == FRAME - 1);
        if (c >= B) begin
            r.an = 4'(1 << k);
            dark = m_disp_bl[k];
            if (lz && k > 0 && m_disp[4*k +: 4] == 4'h0) begin
                z = 1'b1;
                for (int j = k + 1; j < N; j++)
                    if (!(m_disp[4*j +: 4] == 4'h0 || m_disp_bl[j])) z = 1'b0;
                if (z) dark = 1'b1;
            end
            if (!dark) begin
                r.seg = font(m_disp[4*k +: 4]);
                r.dp  = m_disp_dp[k];
            end
        end
        return r;
    endfunction

    function automatic logic [29:0] expect_both(input pins_t h);
        pins_t l;
        l     = h;
        l.an  = ~h.an;
        l.seg = ~h.seg;
        l.dp  = ~h.dp;
        return {l, h};
    endfunction

    task automatic model_reset();
        m_pos = 0;
        m_disp = '0; m_pend = '0;
        m_disp_dp = '0; m_pend_dp = '0; m_disp_bl = '0; m_pend_bl = '0;
        m_pv = 1'b0;
        sb.delete();
    endtask

    // Drive load for the coming edge, queue the pins it must produce, step the model.
    task automatic advance(input bit ld);
        load = ld;
        sb.push_back(expect_both(model_hi()));
        if (ld) begin
            m_pend = digits; m_pend_dp = dp_in; m_pend_bl = blank_in; m_pv = 1'b1;
        end
        if (enable && m_pos == FRAME - 1) begin
            if (ld) begin
                m_disp = digits; m_disp_dp = dp_in; m_disp_bl = blank_in; m_pv = 1'b0;
            end else if (m_pv) begin
                m_disp = m_pend; m_disp_dp = m_pend_dp; m_disp_bl = m_pend_bl; m_pv = 1'b0;
            end
        end
        m_pos = enable ? (m_pos + 1) % FRAME : 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; lz = 1'b0; load = 1'b0;
        digits = 16'h1234; dp_in = '0; blank_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if (got !== expect_both('0)) begin
            n_fail++;
            $display("FAIL reset_pins: got %h expected %h", got, expect_both('0));
        end
        rst_n = 1'b1;
        advance(1'b1);
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            exp_v = (sb.size() != 0) ? sb.pop_front() : 'x;
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL initial_scan cyc %0d: got %h expected %h", i, got, exp_v);
            end
            digits = 16'($urandom);
            advance(1'b0);
        end
    endtask

    task automatic test_tear_free();
        int stage = 0;
        bit ld;
        for (int i = 0; i < 6 * FRAME; i++) begin
            @(negedge clk);
            exp_v = (sb.size() != 0) ? sb.pop_front() : 'x;
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL tear_free cyc %0d: got %h expected %h", i, got, exp_v);
            end
            ld = 1'b0;
            if      (stage == 0 && m_pos == 6)         begin digits = 16'hABCD; ld = 1'b1; end
            else if (stage == 1 && m_pos == 3)         begin digits = 16'h1111; ld = 1'b1; end
            else if (stage == 2 && m_pos == 8)         begin digits = 16'h2222; ld = 1'b1; end
            else if (stage == 3 && m_pos == FRAME - 1) begin digits = 16'h9876; ld = 1'b1; end
            if (ld) stage++;
            else digits = 16'($urandom);
            advance(ld);
        end
    endtask

    task automatic test_lz();
        bit ld;
        lz = 1'b1;
        for (int i = 0; i < 6 * FRAME; i++) begin
            @(negedge clk);
            exp_v = (sb.size() != 0) ? sb.pop_front() : 'x;
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL lz_suppress cyc %0d: got %h expected %h", i, got, exp_v);
            end
            ld = 1'b1;
            blank_in = 4'b0000;
            if      (i == 0)  digits = 16'h0050;
            else if (i == 32) digits = 16'h0000;
            else if (i == 64) begin digits = 16'h1050; blank_in = 4'b1000; end
            else begin ld = 1'b0; digits = 16'($urandom); end
            advance(ld);
        end
        blank_in = '0;
    endtask

    task automatic test_blank_dp();
        bit ld;
        lz = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            exp_v = (sb.size() != 0) ? sb.pop_front() : 'x;
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL blank_dp cyc %0d: got %h expected %h", i, got, exp_v);
            end
            ld = (i == 0);
            digits   = ld ? 16'h6E7F : 16'($urandom);
            blank_in = ld ? 4'b0100 : 4'($urandom);
            dp_in    = ld ? 4'b0001 : 4'($urandom);
            advance(ld);
        end
        blank_in = '0;
        dp_in = '0;
    endtask

    task automatic test_enable_toggle();
        bit ld;
        for (int i = 0; i < 5 * FRAME; i++) begin
            @(negedge clk);
            exp_v = (sb.size() != 0) ? sb.pop_front() : 'x;
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL enable_toggle cyc %0d: got %h expected %h", i, got, exp_v);
            end
            enable = !(i >= 7 && i < 13);
            ld = (i == 9);
            digits = ld ? 16'h5AFE : 16'($urandom);
            advance(ld);
        end
        enable = 1'b1;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < FRAME + 6; i++) begin
            @(negedge clk);
            exp_v = (sb.size() != 0) ? sb.pop_front() : 'x;
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL pre_reset cyc %0d: got %h expected %h", i, got, exp_v);
            end
            advance(1'b0);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (got !== expect_both('0)) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", got, expect_both('0));
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        advance(1'b0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            exp_v = (sb.size() != 0) ? sb.pop_front() : 'x;
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL post_reset cyc %0d: got %h expected %h", i, got, exp_v);
            end
            advance(1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_tear_free();
        test_lz();
        test_blank_dp();
        test_enable_toggle();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
